// File: rtl/rib_arbiter_if.sv
// Bus bundle for the three-master register interface bus arbiter.
// The slave modport is the arbiter's view (it serves the masters and drives the slave port).
// The master modport is the view of the surrounding requesters and the downstream slave.
interface rib_arbiter_if;
    logic        m0_req_i;
    logic        m1_req_i;
    logic        m2_req_i;
    logic        m0_we_i;
    logic        m1_we_i;
    logic        m2_we_i;
    logic [31:0] m0_addr_i;
    logic [31:0] m1_addr_i;
    logic [31:0] m2_addr_i;
    logic [31:0] m0_wdata_i;
    logic [31:0] m1_wdata_i;
    logic [31:0] m2_wdata_i;
    logic        m0_ack_o;
    logic        m1_ack_o;
    logic        m2_ack_o;
    logic        m0_err_o;
    logic        m1_err_o;
    logic        m2_err_o;
    logic [31:0] mx_rdata_o;
    logic        s_req_o;
    logic        s_we_o;
    logic [31:0] s_addr_o;
    logic [31:0] s_wdata_o;
    logic        s_ack_i;
    logic [31:0] s_rdata_i;
    logic        rib_hold_o;
    logic [1:0]  owner_o;

    modport slave (
        input  m0_req_i, m1_req_i, m2_req_i,
        input  m0_we_i, m1_we_i, m2_we_i,
        input  m0_addr_i, m1_addr_i, m2_addr_i,
        input  m0_wdata_i, m1_wdata_i, m2_wdata_i,
        input  s_ack_i, s_rdata_i,
        output m0_ack_o, m1_ack_o, m2_ack_o,
        output m0_err_o, m1_err_o, m2_err_o,
        output mx_rdata_o,
        output s_req_o, s_we_o, s_addr_o, s_wdata_o,
        output rib_hold_o, owner_o
    );

    modport master (
        output m0_req_i, m1_req_i, m2_req_i,
        output m0_we_i, m1_we_i, m2_we_i,
        output m0_addr_i, m1_addr_i, m2_addr_i,
        output m0_wdata_i, m1_wdata_i, m2_wdata_i,
        output s_ack_i, s_rdata_i,
        input  m0_ack_o, m1_ack_o, m2_ack_o,
        input  m0_err_o, m1_err_o, m2_err_o,
        input  mx_rdata_o,
        input  s_req_o, s_we_o, s_addr_o, s_wdata_o,
        input  rib_hold_o, owner_o
    );
endinterface

// File: rtl/rib_arbiter.sv
// Three-master arbiter in front of a single bus slave (m0 = EX data, m1 = IF fetch, m2 = debug).
// One transaction at a time: IDLE picks a winner, BUSY forwards the owner's request until the
// slave acks or a 16-cycle timeout fires. Define RIB_ARB_RR_EN for round-robin arbitration;
// otherwise fixed priority m2 > m0 > m1 is used.
module rib_arbiter (
    input logic          clk,
    input logic          rst_n,
    rib_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [1:0] OWNER_NONE = 2'd3;

    state_t      state;
    logic [1:0]  owner;
    logic [3:0]  tmo_cnt;
    logic [3:0]  req_vec;
    logic        any_req;
    logic [1:0]  winner;
    logic        busy;
    logic        tmo_hit;
    logic        done_ack;
    logic        done_err;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
`ifdef RIB_ARB_RR_EN
    logic [1:0]  last_grant;
    logic [1:0]  cand_a;
    logic [1:0]  cand_b;
`endif

    assign req_vec = {1'b0, bus.m2_req_i, bus.m1_req_i, bus.m0_req_i};
    assign any_req = |req_vec;

`ifdef RIB_ARB_RR_EN
    // Round-robin pick: search starts just after the last granted master and wraps around.
    always_comb begin
        cand_a = (last_grant == 2'd2) ? 2'd0 : last_grant + 2'd1;
        cand_b = (cand_a == 2'd2) ? 2'd0 : cand_a + 2'd1;
        winner = OWNER_NONE;
        if (req_vec[cand_a]) begin
            winner = cand_a;
        end else if (req_vec[cand_b]) begin
            winner = cand_b;
        end else if (req_vec[last_grant]) begin
            winner = last_grant;
        end
    end
`else
    // Fixed-priority pick: debug first, then EX data, fetch last.
    always_comb begin
        winner = OWNER_NONE;
        if (bus.m2_req_i) begin
            winner = 2'd2;
        end else if (bus.m0_req_i) begin
            winner = 2'd0;
        end else if (bus.m1_req_i) begin
            winner = 2'd1;
        end
    end
`endif

    assign busy     = (state == BUSY);
    assign tmo_hit  = (tmo_cnt == 4'hF);
    assign done_ack = busy & bus.s_ack_i;
    assign done_err = busy & ~bus.s_ack_i & tmo_hit;

    // Arbitration FSM: grant in IDLE, hold ownership in BUSY until ack or timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= OWNER_NONE;
            tmo_cnt <= 4'd0;
`ifdef RIB_ARB_RR_EN
            last_grant <= 2'd2;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state   <= BUSY;
                        owner   <= winner;
                        tmo_cnt <= 4'd0;
`ifdef RIB_ARB_RR_EN
                        last_grant <= winner;
`endif
                    end
                end
                BUSY: begin
                    if (bus.s_ack_i || tmo_hit) begin
                        state   <= IDLE;
                        owner   <= OWNER_NONE;
                        tmo_cnt <= 4'd0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    owner <= OWNER_NONE;
                end
            endcase
        end
    end

    // Route the current owner's request fields towards the slave.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = 32'd0;
        sel_wdata = 32'd0;
        case (owner)
            2'd0: begin
                sel_we    = bus.m0_we_i;
                sel_addr  = bus.m0_addr_i;
                sel_wdata = bus.m0_wdata_i;
            end
            2'd1: begin
                sel_we    = bus.m1_we_i;
                sel_addr  = bus.m1_addr_i;
                sel_wdata = bus.m1_wdata_i;
            end
            2'd2: begin
                sel_we    = bus.m2_we_i;
                sel_addr  = bus.m2_addr_i;
                sel_wdata = bus.m2_wdata_i;
            end
            default: begin
                sel_we    = 1'b0;
                sel_addr  = 32'd0;
                sel_wdata = 32'd0;
            end
        endcase
    end

    assign bus.s_req_o   = busy;
    assign bus.s_we_o    = busy & sel_we;
    assign bus.s_addr_o  = busy ? sel_addr  : 32'd0;
    assign bus.s_wdata_o = busy ? sel_wdata : 32'd0;

    assign bus.m0_ack_o = done_ack & (owner == 2'd0);
    assign bus.m1_ack_o = done_ack & (owner == 2'd1);
    assign bus.m2_ack_o = done_ack & (owner == 2'd2);
    assign bus.m0_err_o = done_err & (owner == 2'd0);
    assign bus.m1_err_o = done_err & (owner == 2'd1);
    assign bus.m2_err_o = done_err & (owner == 2'd2);

    assign bus.mx_rdata_o = done_ack ? bus.s_rdata_i : 32'd0;

    // The fetch stage stalls while EX or debug want the bus or already own it.
    assign bus.rib_hold_o = bus.m0_req_i | bus.m2_req_i | (owner == 2'd0) | (owner == 2'd2);
    assign bus.owner_o    = owner;
endmodule

// File: tb/tb_rib_arbiter.sv
// Scoreboard bench for rib_arbiter: directed scenarios followed by randomized rounds.
// A behavioural model predicts grant order and each transaction's outcome; a monitor
// compares every ack/err pulse and the surrounding idle/reset cycles against it.
module tb_rib_arbiter;
    localparam int CLK_HALF = 5;

    typedef struct {
        logic [1:0]  id;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        bit          drop;
    } txn_t;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic        mwe    [3];
    logic [31:0] maddr  [3];
    logic [31:0] mwdata [3];
    logic [31:0] mrdata [3];
    int          mlat   [3];
    int          mcount [3];
    bit          mdrop  [3];
    int          remaining [3];
    int          model_cnt [3];
    logic        s_ack;
    logic [31:0] s_rdata;
    txn_t        exp_q  [$];
    txn_t        plan_q [$];
    txn_t        cur;
    int          sl_cnt;
    int          stall_count;
    bit          end_of_test;
    int          checks_total;
    int          checks_passed;
`ifdef RIB_ARB_RR_EN
    int          model_last;
`endif

    rib_arbiter_if bus();

    rib_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.m0_req_i   = req[0];
    assign bus.m1_req_i   = req[1];
    assign bus.m2_req_i   = req[2];
    assign bus.m0_we_i    = mwe[0];
    assign bus.m1_we_i    = mwe[1];
    assign bus.m2_we_i    = mwe[2];
    assign bus.m0_addr_i  = maddr[0];
    assign bus.m1_addr_i  = maddr[1];
    assign bus.m2_addr_i  = maddr[2];
    assign bus.m0_wdata_i = mwdata[0];
    assign bus.m1_wdata_i = mwdata[1];
    assign bus.m2_wdata_i = mwdata[2];
    assign bus.s_ack_i    = s_ack;
    assign bus.s_rdata_i  = s_rdata;

    // Free-running core clock.
    initial begin
        clk = 1'b0;
        forever #CLK_HALF clk = ~clk;
    end

    // Hard time limit so a wedged run still ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got still running, expected finished");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Next grant according to the arbitration rule, among masters still wanting the bus.
    function automatic int pickWinner();
        int order [3];
`ifdef RIB_ARB_RR_EN
        for (int s = 0; s < 3; s++) order[s] = (model_last + 1 + s) % 3;
`else
        order[0] = 2;
        order[1] = 0;
        order[2] = 1;
`endif
        for (int s = 0; s < 3; s++) begin
            if (model_cnt[order[s]] > 0) return order[s];
        end
        return -1;
    endfunction

    // Expand the per-master request counts into the predicted transaction sequence.
    task automatic planRound();
        bit   first [3];
        int   w;
        txn_t t;
        for (int k = 0; k < 3; k++) begin
            model_cnt[k] = mcount[k];
            first[k]     = 1'b1;
        end
        w = pickWinner();
        while (w >= 0) begin
            t.id    = 2'(w);
            t.we    = mwe[w];
            t.addr  = maddr[w];
            t.wdata = mwdata[w];
            if (first[w]) begin
                t.lat    = mlat[w];
                t.rdata  = mrdata[w];
                first[w] = 1'b0;
            end else begin
                t.lat   = int'($urandom_range(1, 5));
                t.rdata = $urandom;
            end
            model_cnt[w]--;
            t.drop = (model_cnt[w] == 0) && mdrop[w];
            exp_q.push_back(t);
            plan_q.push_back(t);
`ifdef RIB_ARB_RR_EN
            model_last = w;
`endif
            w = pickWinner();
        end
    endtask

    // Slave model: acks in the planned BUSY cycle, otherwise returns noise on rdata.
    task automatic slaveStep();
        if (bus.s_req_o) begin
            if (sl_cnt == 0) begin
                if (plan_q.size() > 0) begin
                    cur = plan_q.pop_front();
                end else begin
                    cur.id = 2'd0; cur.we = 1'b0; cur.addr = 32'd0; cur.wdata = 32'd0;
                    cur.rdata = 32'd0; cur.lat = 0; cur.drop = 1'b0;
                end
                if (cur.drop) req[cur.id] = 1'b0;
            end
            sl_cnt++;
            if (cur.lat != 0 && sl_cnt == cur.lat) begin
                s_ack   = 1'b1;
                s_rdata = cur.rdata;
            end else begin
                s_ack   = 1'b0;
                s_rdata = $urandom;
            end
        end else begin
            sl_cnt  = 0;
            s_ack   = 1'b0;
            s_rdata = $urandom;
        end
    endtask

    // Clock the bus until every outstanding master request has completed (bounded).
    task automatic runRound(input int budget);
        int         cyc;
        logic [2:0] resp;
        cyc = 0;
        while ((remaining[0] + remaining[1] + remaining[2]) > 0 && cyc < budget) begin
            @(posedge clk); #1; slaveStep();
            @(negedge clk);
            resp = {bus.m2_ack_o | bus.m2_err_o, bus.m1_ack_o | bus.m1_err_o, bus.m0_ack_o | bus.m0_err_o};
            #1;
            for (int k = 0; k < 3; k++) begin
                if (resp[k] && remaining[k] > 0) begin
                    remaining[k]--;
                    if (remaining[k] == 0) req[k] = 1'b0;
                end
            end
            cyc++;
        end
        if ((remaining[0] + remaining[1] + remaining[2]) > 0) begin
            stall_count++;
            for (int k = 0; k < 3; k++) begin
                remaining[k] = 0;
                req[k]       = 1'b0;
            end
        end
        @(posedge clk); #1; slaveStep();
    endtask

    task automatic clearMasters();
        for (int k = 0; k < 3; k++) begin
            mwe[k] = 1'b0; maddr[k] = 32'd0; mwdata[k] = 32'd0; mrdata[k] = 32'd0;
            mlat[k] = 1; mcount[k] = 0; mdrop[k] = 1'b0;
        end
    endtask

    task automatic setMaster(input int k, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int lat, input logic [31:0] rdata,
                             input int count, input bit drop);
        mwe[k] = we; maddr[k] = addr; mwdata[k] = wdata;
        mlat[k] = lat; mrdata[k] = rdata; mcount[k] = count; mdrop[k] = drop;
    endtask

    // Issue one round: predict it, raise the requests, then run it to completion.
    task automatic applyStimulus();
        planRound();
        for (int k = 0; k < 3; k++) begin
            remaining[k] = mcount[k];
            req[k]       = (mcount[k] > 0);
        end
        runRound(400);
    endtask

    // m2 access killed by reset in its third BUSY cycle while m1 waits.
    task automatic resetScenario();
        txn_t d;
        clearMasters();
        setMaster(2, 1'b1, 32'h0000_2000, 32'h1234_5678, 0, 32'd0, 0, 1'b0);
        d.id = 2'd2; d.we = 1'b1; d.addr = 32'h0000_2000; d.wdata = 32'h1234_5678;
        d.rdata = 32'd0; d.lat = 0; d.drop = 1'b0;
        plan_q.push_back(d);
        req[2] = 1'b1;
        @(posedge clk); #1; slaveStep();
        setMaster(1, 1'b0, 32'h0000_0400, 32'd0, 2, 32'hCAFE_F00D, 1, 1'b0);
`ifdef RIB_ARB_RR_EN
        model_last = 2;
`endif
        planRound();
        remaining[1] = 1;
        req[1]       = 1'b1;
        @(posedge clk); #1; slaveStep();
        @(posedge clk); #1; slaveStep();
        rst_n = 1'b0;
        @(negedge clk); #1;
        req[2] = 1'b0;
        @(posedge clk); #1; slaveStep();
        @(negedge clk); #1;
        rst_n = 1'b1;
        runRound(100);
    endtask

    // Main stimulus sequence: directed scenarios, then randomized rounds.
    initial begin
        rst_n = 1'b0; req = 3'b000; s_ack = 1'b0; s_rdata = 32'd0;
        sl_cnt = 0; stall_count = 0; end_of_test = 1'b0;
        for (int k = 0; k < 3; k++) remaining[k] = 0;
`ifdef RIB_ARB_RR_EN
        model_last = 2;
`endif
        clearMasters();
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        clearMasters();
        setMaster(1, 1'b0, 32'h0000_0100, 32'd0, 2, 32'hDEAD_BEEF, 1, 1'b0);
        applyStimulus();

        clearMasters();
        setMaster(0, 1'b1, 32'h0000_0010, 32'h0000_00A0, 3, 32'h1111_0000, 1, 1'b0);
        setMaster(1, 1'b0, 32'h0000_0014, 32'h0000_00B0, 3, 32'h2222_0000, 1, 1'b0);
        setMaster(2, 1'b0, 32'h0000_0018, 32'h0000_00C0, 3, 32'h3333_0000, 1, 1'b0);
        applyStimulus();

        clearMasters();
        setMaster(0, 1'b1, 32'h0000_0200, 32'h55AA_55AA, 0, 32'd0, 1, 1'b0);
        applyStimulus();

        clearMasters();
        setMaster(0, 1'b1, 32'h0000_0204, 32'h0F0F_0F0F, 16, 32'h600D_600D, 1, 1'b0);
        applyStimulus();

        resetScenario();

        clearMasters();
        setMaster(0, 1'b0, 32'h0000_0300, 32'd0, 1, 32'h0000_0011, 2, 1'b0);
        setMaster(1, 1'b0, 32'h0000_0304, 32'd0, 1, 32'h0000_0022, 2, 1'b0);
        applyStimulus();

        for (int r = 0; r < 40; r++) begin
            clearMasters();
            for (int k = 0; k < 3; k++) begin
                int sel;
                sel = int'($urandom_range(0, 9));
                setMaster(k, 1'($urandom_range(0, 1)), $urandom, $urandom,
                          (sel == 0) ? 0 : (sel == 1) ? 16 : int'($urandom_range(1, 6)),
                          $urandom, int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0));
            end
            if (mcount[0] + mcount[1] + mcount[2] == 0) mcount[$urandom_range(0, 2)] = 1;
            applyStimulus();
        end

        end_of_test = 1'b1;
    end

    // Monitor: compares every completion pulse, the idle cycle after it and reset cycles.
    initial begin
        txn_t       t;
        logic [2:0] acks;
        logic [2:0] errs;
        logic [2:0] exp_ack;
        logic [2:0] exp_err;
        int         busy_cnt;
        bit         idle_next;
        checks_total  = 0;
        checks_passed = 0;
        busy_cnt      = 0;
        idle_next     = 1'b0;
        while (!end_of_test) begin
            @(negedge clk);
            acks = {bus.m2_ack_o, bus.m1_ack_o, bus.m0_ack_o};
            errs = {bus.m2_err_o, bus.m1_err_o, bus.m0_err_o};
            if (!rst_n) begin
                checkOutput("rst_owner", 32'(bus.owner_o), 32'd3);
                checkOutput("rst_s_req", 32'(bus.s_req_o), 32'd0);
                checkOutput("rst_s_we", 32'(bus.s_we_o), 32'd0);
                checkOutput("rst_s_addr", bus.s_addr_o, 32'd0);
                checkOutput("rst_s_wdata", bus.s_wdata_o, 32'd0);
                checkOutput("rst_ack_err", 32'({acks, errs}), 32'd0);
                checkOutput("rst_rdata", bus.mx_rdata_o, 32'd0);
                checkOutput("rst_hold", 32'(bus.rib_hold_o), 32'(bus.m0_req_i | bus.m2_req_i));
                busy_cnt  = 0;
                idle_next = 1'b0;
            end else begin
                if (bus.s_req_o) busy_cnt++;
                else busy_cnt = 0;
                if ((acks | errs) != 3'b000) begin
                    checkOutput("single_response", 32'($countones({acks, errs})), 32'd1);
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_response", 32'({acks, errs}), 32'd0);
                    end else begin
                        t = exp_q.pop_front();
                        exp_ack = (t.lat == 0) ? 3'b000 : (3'b001 << t.id);
                        exp_err = (t.lat == 0) ? (3'b001 << t.id) : 3'b000;
                        checkOutput("ack_vector", 32'(acks), 32'(exp_ack));
                        checkOutput("err_vector", 32'(errs), 32'(exp_err));
                        checkOutput("mx_rdata", bus.mx_rdata_o, (t.lat == 0) ? 32'd0 : t.rdata);
                        checkOutput("busy_cycles", 32'(busy_cnt), (t.lat == 0) ? 32'd16 : 32'(t.lat));
                        checkOutput("owner", 32'(bus.owner_o), 32'(t.id));
                        checkOutput("s_req", 32'(bus.s_req_o), 32'd1);
                        checkOutput("s_we", 32'(bus.s_we_o), 32'(t.we));
                        checkOutput("s_addr", bus.s_addr_o, t.addr);
                        checkOutput("s_wdata", bus.s_wdata_o, t.wdata);
                        checkOutput("hold_busy", 32'(bus.rib_hold_o),
                                    32'(bus.m0_req_i | bus.m2_req_i | (t.id != 2'd1)));
                    end
                    idle_next = 1'b1;
                end else begin
                    checkOutput("rdata_quiet", bus.mx_rdata_o, 32'd0);
                    if (idle_next) begin
                        checkOutput("idle_owner", 32'(bus.owner_o), 32'd3);
                        checkOutput("idle_s_req", 32'(bus.s_req_o), 32'd0);
                        checkOutput("idle_s_we", 32'(bus.s_we_o), 32'd0);
                        checkOutput("idle_s_addr", bus.s_addr_o, 32'd0);
                        checkOutput("idle_s_wdata", bus.s_wdata_o, 32'd0);
                        checkOutput("idle_hold", 32'(bus.rib_hold_o), 32'(bus.m0_req_i | bus.m2_req_i));
                        idle_next = 1'b0;
                    end
                end
            end
        end
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("no_stall", 32'(stall_count), 32'd0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
